// File: rtl/wt_mem_port_arbiter.sv
// wt_mem_port_arbiter
// Shares the single memory request port of the write-through cache subsystem
// among the I-cache refill (0), D-cache read miss (1) and write-buffer store (2)
// requesters. It caps the number of un-acked stores, holds back D-cache reads to
// the non-idempotent region while stores are in flight, and provides a drain
// handshake for fence/flush.
// Optional build macro: WT_MEM_ARB_PERF_EN adds perf_stall_o, which holds
// per-requester stall-cycle counters.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no request presented; arbitrate among eligible requesters
// ST_HOLD  | granted request presented on mem_*, waiting for mem_ready_i
// ST_DRAIN | no new grants; waiting for the outstanding store count to reach 0

module wt_mem_port_arbiter #(
    parameter int                 ADDR_W         = 32,
    parameter int                 DATA_W         = 64,
    parameter int                 TID_W          = 2,
    parameter int                 MAX_OUT_STORES = 7,
    parameter logic [ADDR_W-1:0]  NI_BASE        = 32'h0000_0000,
    parameter logic [ADDR_W-1:0]  NI_LEN         = 32'h0001_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [2:0]            req_valid_i,
    output logic [2:0]            req_ready_o,
    input  logic [3*ADDR_W-1:0]   req_addr_i,
    input  logic [3*TID_W-1:0]    req_tid_i,
    input  logic [DATA_W-1:0]     st_data_i,
    input  logic [DATA_W/8-1:0]   st_be_i,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic                  mem_is_store_o,
    output logic [DATA_W-1:0]     mem_data_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    output logic [TID_W+1:0]      mem_tid_o,
    input  logic                  rtrn_valid_i,
    input  logic [TID_W+1:0]      rtrn_tid_i,
    output logic [2:0]            rtrn_valid_o,
    output logic [TID_W-1:0]      rtrn_tid_o,
    input  logic                  drain_req_i,
    output logic                  drain_done_o,
    output logic [2:0]            st_cnt_o
`ifdef WT_MEM_ARB_PERF_EN
    ,
    output logic [3*16-1:0]       perf_stall_o
`endif
);

    localparam logic [2:0] LP_MAX_ST = 3'(MAX_OUT_STORES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [1:0]           r_rr;
    logic [2:0]           r_st_cnt;
    logic                 r_drain_hold;

    logic [ADDR_W-1:0]    r_mem_addr;
    logic                 r_mem_is_store;
    logic [DATA_W-1:0]    r_mem_data;
    logic [DATA_W/8-1:0]  r_mem_be;
    logic [TID_W+1:0]     r_mem_tid;

    logic [ADDR_W-1:0]    w_ni_off;
    logic                 w_in_ni;
    logic [2:0]           w_elig;
    logic [1:0]           w_win_id;
    logic                 w_win_any;
    logic [ADDR_W-1:0]    w_win_addr;
    logic [TID_W-1:0]     w_win_tid;
    logic                 w_drain_enter;
    logic                 w_grant;
    logic                 w_mem_hs;
    logic                 w_st_inc;
    logic                 w_st_dec;
    logic [1:0]           w_rtrn_id;

    // Modular offset keeps the region check correct even when NI_BASE is 0.
    assign w_ni_off  = req_addr_i[ADDR_W +: ADDR_W] - NI_BASE;
    assign w_in_ni   = (w_ni_off < NI_LEN);

    assign w_elig[0] = req_valid_i[0];
    assign w_elig[1] = req_valid_i[1] && !(w_in_ni && (r_st_cnt != 3'd0));
    assign w_elig[2] = req_valid_i[2] && (r_st_cnt < LP_MAX_ST);
    assign w_win_any = |w_elig;

    // After a completed drain the level request must fall before it can re-arm.
    assign w_drain_enter = drain_req_i && !r_drain_hold;
    assign w_grant       = (r_state == ST_IDLE) && !w_drain_enter && w_win_any && !rst_i;
    assign w_mem_hs      = (r_state == ST_HOLD) && mem_ready_i;
    assign w_st_inc      = w_mem_hs && r_mem_is_store;
    assign w_rtrn_id     = rtrn_tid_i[TID_W+1:TID_W];
    assign w_st_dec      = rtrn_valid_i && (w_rtrn_id == 2'd2) && (r_st_cnt != 3'd0);

    // Round-robin pick starting at the rr pointer.
    always_comb begin
        w_win_id = 2'd0;
        case (r_rr)
            2'd1: begin
                if (w_elig[1])      w_win_id = 2'd1;
                else if (w_elig[2]) w_win_id = 2'd2;
                else                w_win_id = 2'd0;
            end
            2'd2: begin
                if (w_elig[2])      w_win_id = 2'd2;
                else if (w_elig[0]) w_win_id = 2'd0;
                else                w_win_id = 2'd1;
            end
            default: begin
                if (w_elig[0])      w_win_id = 2'd0;
                else if (w_elig[1]) w_win_id = 2'd1;
                else                w_win_id = 2'd2;
            end
        endcase
    end

    // Select the winner's address and local tid.
    always_comb begin
        w_win_addr = req_addr_i[0 +: ADDR_W];
        w_win_tid  = req_tid_i[0 +: TID_W];
        case (w_win_id)
            2'd1: begin
                w_win_addr = req_addr_i[ADDR_W +: ADDR_W];
                w_win_tid  = req_tid_i[TID_W +: TID_W];
            end
            2'd2: begin
                w_win_addr = req_addr_i[2*ADDR_W +: ADDR_W];
                w_win_tid  = req_tid_i[2*TID_W +: TID_W];
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_drain_enter)  w_state_nxt = ST_DRAIN;
                else if (w_win_any) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (mem_ready_i) w_state_nxt = w_drain_enter ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (r_st_cnt == 3'd0) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and the current grant.
    always_comb begin
        req_ready_o  = 3'b000;
        if (w_grant) req_ready_o[w_win_id] = 1'b1;
        mem_valid_o  = (r_state == ST_HOLD);
        drain_done_o = (r_state == ST_DRAIN) && (r_st_cnt == 3'd0);
    end

    // Capture the granted request; held stable for the whole HOLD phase.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mem_addr     <= '0;
            r_mem_is_store <= 1'b0;
            r_mem_data     <= '0;
            r_mem_be       <= '0;
            r_mem_tid      <= '0;
        end else if (w_grant) begin
            r_mem_addr     <= w_win_addr;
            r_mem_is_store <= (w_win_id == 2'd2);
            r_mem_data     <= (w_win_id == 2'd2) ? st_data_i : '0;
            r_mem_be       <= (w_win_id == 2'd2) ? st_be_i : '0;
            r_mem_tid      <= {w_win_id, w_win_tid};
        end
    end

    // Advance the rr pointer past the winner once memory accepts it.
    always_ff @(posedge clk_i) begin
        if (rst_i)         r_rr <= 2'd0;
        else if (w_mem_hs) r_rr <= (r_mem_tid[TID_W+1:TID_W] == 2'd2) ? 2'd0
                                   : r_mem_tid[TID_W+1:TID_W] + 2'd1;
    end

    // Outstanding store count; simultaneous issue and ack cancel out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_st_cnt <= 3'd0;
        end else begin
            case ({w_st_inc, w_st_dec})
                2'b10:   r_st_cnt <= r_st_cnt + 3'd1;
                2'b01:   r_st_cnt <= r_st_cnt - 3'd1;
                default: r_st_cnt <= r_st_cnt;
            endcase
        end
    end

    // Block drain re-entry until the level request has been released.
    always_ff @(posedge clk_i) begin
        if (rst_i)                                          r_drain_hold <= 1'b0;
        else if ((r_state == ST_DRAIN) && (r_st_cnt == 3'd0)) r_drain_hold <= 1'b1;
        else if (!drain_req_i)                              r_drain_hold <= 1'b0;
    end

    // Response routing is purely combinational; tag id 3 is dropped.
    always_comb begin
        rtrn_valid_o = 3'b000;
        if (rtrn_valid_i && (w_rtrn_id != 2'd3)) rtrn_valid_o[w_rtrn_id] = 1'b1;
        rtrn_tid_o   = rtrn_tid_i[TID_W-1:0];
    end

    assign mem_addr_o     = r_mem_addr;
    assign mem_is_store_o = r_mem_is_store;
    assign mem_data_o     = r_mem_data;
    assign mem_be_o       = r_mem_be;
    assign mem_tid_o      = r_mem_tid;
    assign st_cnt_o       = r_st_cnt;

`ifdef WT_MEM_ARB_PERF_EN
    logic [15:0] r_perf [3];

    // Saturating count of cycles each requester waits with valid high.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_i)
                r_perf[k] <= 16'd0;
            else if (req_valid_i[k] && !req_ready_o[k] && (r_perf[k] != 16'hFFFF))
                r_perf[k] <= r_perf[k] + 16'd1;
        end
    end

    assign perf_stall_o = {r_perf[2], r_perf[1], r_perf[0]};
`endif

`ifndef SYNTHESIS
    // A store ack with nothing outstanding means the memory side lost track.
    a_ack_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(rtrn_valid_i && (w_rtrn_id == 2'd2) && (r_st_cnt == 3'd0)));

    // No requester owns tag id 3.
    a_bad_rtrn_tag: assert property (@(posedge clk_i) disable iff (rst_i)
        !(rtrn_valid_i && (w_rtrn_id == 2'd3)));
`endif

endmodule

// File: tb/tb_wt_mem_port_arbiter.sv
// Directed, table-driven bench for wt_mem_port_arbiter (default parameters).
module tb_wt_mem_port_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [2:0]   req_valid_i;
    logic [2:0]   req_ready_o;
    logic [95:0]  req_addr_i;
    logic [5:0]   req_tid_i;
    logic [63:0]  st_data_i;
    logic [7:0]   st_be_i;
    logic         mem_valid_o;
    logic         mem_ready_i;
    logic [31:0]  mem_addr_o;
    logic         mem_is_store_o;
    logic [63:0]  mem_data_o;
    logic [7:0]   mem_be_o;
    logic [3:0]   mem_tid_o;
    logic         rtrn_valid_i;
    logic [3:0]   rtrn_tid_i;
    logic [2:0]   rtrn_valid_o;
    logic [1:0]   rtrn_tid_o;
    logic         drain_req_i;
    logic         drain_done_o;
    logic [2:0]   st_cnt_o;
`ifdef WT_MEM_ARB_PERF_EN
    logic [47:0]  perf_stall_o;
`endif

    int n_chk = 0;
    int n_err = 0;

    wt_mem_port_arbiter dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .req_tid_i      (req_tid_i),
        .st_data_i      (st_data_i),
        .st_be_i        (st_be_i),
        .mem_valid_o    (mem_valid_o),
        .mem_ready_i    (mem_ready_i),
        .mem_addr_o     (mem_addr_o),
        .mem_is_store_o (mem_is_store_o),
        .mem_data_o     (mem_data_o),
        .mem_be_o       (mem_be_o),
        .mem_tid_o      (mem_tid_o),
        .rtrn_valid_i   (rtrn_valid_i),
        .rtrn_tid_i     (rtrn_tid_i),
        .rtrn_valid_o   (rtrn_valid_o),
        .rtrn_tid_o     (rtrn_tid_o),
        .drain_req_i    (drain_req_i),
        .drain_done_o   (drain_done_o),
        .st_cnt_o       (st_cnt_o)
`ifdef WT_MEM_ARB_PERF_EN
        ,
        .perf_stall_o   (perf_stall_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0] valid;
        logic       rv;
        logic [3:0] rtid;
        logic [2:0] e_ready;
        logic       e_mvalid;
        logic [3:0] e_mtid;
        logic [2:0] e_cnt;
        logic [2:0] e_rvo;
    } rr_vec_t;

    typedef struct {
        logic       rv;
        logic [3:0] rtid;
        logic [2:0] e_rvo;
        logic [1:0] e_tid;
    } rt_vec_t;

    rr_vec_t rr_tab [13];
    rt_vec_t rt_tab [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        req_valid_i  = 3'b000;
        req_addr_i   = '0;
        req_tid_i    = '0;
        st_data_i    = 64'hA5A5_0000_1234_5678;
        st_be_i      = 8'hF0;
        mem_ready_i  = 1'b1;
        rtrn_valid_i = 1'b0;
        rtrn_tid_i   = 4'd0;
        drain_req_i  = 1'b0;
        repeat (3) step();
        rst_i = 1'b0;
    endtask

    // One store from requester 2 in IDLE with mem_ready_i high: grant, then handshake.
    task automatic issue_store();
        req_valid_i = 3'b100;
        smp();
        chk("store_grant", req_ready_o, 3'b100);
        step();
        req_valid_i = 3'b000;
        smp();
        step();
    endtask

    initial begin
        int grants;

        //            valid   rv    rtid     ready   mv    mtid     cnt   rvo
        rr_tab[0]  = '{3'b111, 1'b0, 4'b0000, 3'b001, 1'b0, 4'b0000, 3'd0, 3'b000};
        rr_tab[1]  = '{3'b111, 1'b0, 4'b0000, 3'b000, 1'b1, 4'b0001, 3'd0, 3'b000};
        rr_tab[2]  = '{3'b111, 1'b0, 4'b0000, 3'b010, 1'b0, 4'b0001, 3'd0, 3'b000};
        rr_tab[3]  = '{3'b111, 1'b0, 4'b0000, 3'b000, 1'b1, 4'b0110, 3'd0, 3'b000};
        rr_tab[4]  = '{3'b111, 1'b0, 4'b0000, 3'b100, 1'b0, 4'b0110, 3'd0, 3'b000};
        rr_tab[5]  = '{3'b111, 1'b0, 4'b0000, 3'b000, 1'b1, 4'b1011, 3'd0, 3'b000};
        rr_tab[6]  = '{3'b111, 1'b1, 4'b1011, 3'b001, 1'b0, 4'b1011, 3'd1, 3'b100};
        rr_tab[7]  = '{3'b111, 1'b0, 4'b0000, 3'b000, 1'b1, 4'b0001, 3'd0, 3'b000};
        rr_tab[8]  = '{3'b111, 1'b0, 4'b0000, 3'b010, 1'b0, 4'b0001, 3'd0, 3'b000};
        rr_tab[9]  = '{3'b111, 1'b0, 4'b0000, 3'b000, 1'b1, 4'b0110, 3'd0, 3'b000};
        rr_tab[10] = '{3'b111, 1'b0, 4'b0000, 3'b100, 1'b0, 4'b0110, 3'd0, 3'b000};
        rr_tab[11] = '{3'b111, 1'b0, 4'b0000, 3'b000, 1'b1, 4'b1011, 3'd0, 3'b000};
        rr_tab[12] = '{3'b111, 1'b1, 4'b1011, 3'b001, 1'b0, 4'b1011, 3'd1, 3'b100};

        rt_tab[0]  = '{1'b1, 4'b0010, 3'b001, 2'b10};
        rt_tab[1]  = '{1'b1, 4'b0111, 3'b010, 2'b11};
        rt_tab[2]  = '{1'b0, 4'b0101, 3'b000, 2'b01};
        rt_tab[3]  = '{1'b1, 4'b0100, 3'b010, 2'b00};

        // Reset state
        do_reset();
        smp();
        chk("rst_mem_valid", mem_valid_o, 1'b0);
        chk("rst_ready", req_ready_o, 3'b000);
        chk("rst_cnt", st_cnt_o, 3'd0);
        chk("rst_done", drain_done_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_tid", mem_tid_o, 4'h0);
        chk("rst_rtrn_valid", rtrn_valid_o, 3'b000);
        step();

        // Response routing, idle
        for (int i = 0; i < 4; i++) begin
            rtrn_valid_i = rt_tab[i].rv;
            rtrn_tid_i   = rt_tab[i].rtid;
            smp();
            chk("route_valid", rtrn_valid_o, rt_tab[i].e_rvo);
            chk("route_tid", rtrn_tid_o, rt_tab[i].e_tid);
            step();
        end
        rtrn_valid_i = 1'b0;

        // Round robin, all valid, immediate store ack
        do_reset();
        req_addr_i = {32'h2000_0000, 32'h8000_0000, 32'h1000_0000};
        req_tid_i  = {2'd3, 2'd2, 2'd1};
        for (int i = 0; i < 13; i++) begin
            req_valid_i  = rr_tab[i].valid;
            rtrn_valid_i = rr_tab[i].rv;
            rtrn_tid_i   = rr_tab[i].rtid;
            smp();
            chk("rr_ready", req_ready_o, rr_tab[i].e_ready);
            chk("rr_mem_valid", mem_valid_o, rr_tab[i].e_mvalid);
            chk("rr_mem_tid", mem_tid_o, rr_tab[i].e_mtid);
            chk("rr_cnt", st_cnt_o, rr_tab[i].e_cnt);
            chk("rr_rtrn_valid", rtrn_valid_o, rr_tab[i].e_rvo);
            if (rr_tab[i].e_mvalid && rr_tab[i].e_mtid[3:2] == 2'd2) begin
                chk("rr_store_flag", mem_is_store_o, 1'b1);
                chk("rr_store_data", mem_data_o, 64'hA5A5_0000_1234_5678);
                chk("rr_store_be", mem_be_o, 8'hF0);
            end
            step();
        end
        rtrn_valid_i = 1'b0;

        // Store flood without acks: cap at 7
        do_reset();
        req_addr_i  = {32'h2000_0000, 32'h8000_0000, 32'h1000_0000};
        req_valid_i = 3'b100;
        grants = 0;
        for (int i = 0; i < 20; i++) begin
            smp();
            if (req_ready_o[2]) grants++;
            step();
        end
        chk("flood_grants", grants, 7);
        rtrn_valid_i = 1'b1;
        rtrn_tid_i   = 4'b1000;
        smp();
        chk("flood_cnt", st_cnt_o, 3'd7);
        chk("flood_stall", req_ready_o, 3'b000);
        step();
        rtrn_valid_i = 1'b0;
        smp();
        chk("flood_regrant", req_ready_o, 3'b100);
        chk("flood_cnt_after_ack", st_cnt_o, 3'd6);
        step();
        smp();
        chk("flood_8th_mem_valid", mem_valid_o, 1'b1);
        step();
        smp();
        chk("flood_cnt_back", st_cnt_o, 3'd7);
        chk("flood_stall2", req_ready_o, 3'b000);
        step();

        // Non-idempotent read ordering
        do_reset();
        req_addr_i = {32'h2000_0000, 32'h0000_0010, 32'h0000_1000};
        req_tid_i  = {2'd0, 2'd1, 2'd2};
        issue_store();
        issue_store();
        req_valid_i = 3'b010;
        smp();
        chk("ni_cnt2", st_cnt_o, 3'd2);
        chk("ni_blocked", req_ready_o, 3'b000);
        step();
        req_valid_i = 3'b011;
        smp();
        chk("ni_icache_grant", req_ready_o, 3'b001);
        step();
        req_valid_i = 3'b010;
        smp();
        chk("ni_icache_mem_id", mem_tid_o[3:2], 2'd0);
        chk("ni_icache_mem_valid", mem_valid_o, 1'b1);
        step();
        rtrn_valid_i = 1'b1;
        rtrn_tid_i   = 4'b1000;
        smp();
        chk("ni_blocked_ack1", req_ready_o, 3'b000);
        step();
        smp();
        chk("ni_blocked_ack2", req_ready_o, 3'b000);
        chk("ni_cnt1", st_cnt_o, 3'd1);
        step();
        rtrn_valid_i = 1'b0;
        smp();
        chk("ni_read_grant", req_ready_o, 3'b010);
        chk("ni_cnt0", st_cnt_o, 3'd0);
        step();
        req_valid_i = 3'b000;
        smp();
        chk("ni_read_addr", mem_addr_o, 32'h0000_0010);
        chk("ni_read_tid", mem_tid_o, 4'b0101);
        chk("ni_read_not_store", mem_is_store_o, 1'b0);
        step();
        issue_store();
        req_addr_i[63:32] = 32'h8000_0000;
        req_valid_i = 3'b010;
        smp();
        chk("far_cnt1", st_cnt_o, 3'd1);
        chk("far_read_grant", req_ready_o, 3'b010);
        step();
        req_valid_i = 3'b000;
        smp();
        chk("far_read_addr", mem_addr_o, 32'h8000_0000);
        step();

        // Backpressure in HOLD
        do_reset();
        req_addr_i  = {32'h2000_0000, 32'h8000_0000, 32'h1234_5678};
        req_tid_i   = {2'd0, 2'd0, 2'd2};
        req_valid_i = 3'b111;
        mem_ready_i = 1'b0;
        smp();
        chk("bp_grant", req_ready_o, 3'b001);
        step();
        req_addr_i[31:0] = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("bp_mem_valid", mem_valid_o, 1'b1);
            chk("bp_addr", mem_addr_o, 32'h1234_5678);
            chk("bp_tid", mem_tid_o, 4'b0010);
            chk("bp_ready", req_ready_o, 3'b000);
            step();
        end
        mem_ready_i = 1'b1;
        smp();
        chk("bp_hs_ready", req_ready_o, 3'b000);
        step();
        req_valid_i = 3'b000;
        smp();
        chk("bp_released", mem_valid_o, 1'b0);
        step();

        // Drain with 3 stores outstanding
        do_reset();
        req_addr_i = {32'h2000_0000, 32'h8000_0000, 32'h0000_1000};
        issue_store();
        issue_store();
        issue_store();
        req_valid_i = 3'b011;
        drain_req_i = 1'b1;
        smp();
        chk("dr_cnt3", st_cnt_o, 3'd3);
        chk("dr_entry_no_grant", req_ready_o, 3'b000);
        step();
        rtrn_valid_i = 1'b1;
        rtrn_tid_i   = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("dr_no_grant", req_ready_o, 3'b000);
            chk("dr_not_done", drain_done_o, 1'b0);
            step();
        end
        rtrn_valid_i = 1'b0;
        smp();
        chk("dr_done_pulse", drain_done_o, 1'b1);
        chk("dr_cnt0", st_cnt_o, 3'd0);
        chk("dr_done_no_grant", req_ready_o, 3'b000);
        step();
        smp();
        chk("dr_done_single", drain_done_o, 1'b0);
        chk("dr_resume_grant", req_ready_o, 3'b001);
        step();
        drain_req_i = 1'b0;
        req_valid_i = 3'b000;
        step();

        // Drain with nothing outstanding
        do_reset();
        req_valid_i = 3'b001;
        drain_req_i = 1'b1;
        smp();
        chk("dr0_entry_no_grant", req_ready_o, 3'b000);
        chk("dr0_entry_not_done", drain_done_o, 1'b0);
        step();
        smp();
        chk("dr0_done_pulse", drain_done_o, 1'b1);
        step();
        smp();
        chk("dr0_done_single", drain_done_o, 1'b0);
        chk("dr0_no_reentry", req_ready_o, 3'b001);
        step();
        drain_req_i = 1'b0;
        req_valid_i = 3'b000;
        step();

        // Reset during HOLD with 4 stores outstanding
        do_reset();
        req_addr_i = {32'h2000_0000, 32'h8000_0000, 32'h0000_1000};
        repeat (4) issue_store();
        req_valid_i = 3'b100;
        smp();
        chk("rh_grant", req_ready_o, 3'b100);
        step();
        req_valid_i = 3'b000;
        mem_ready_i = 1'b0;
        rst_i       = 1'b1;
        smp();
        chk("rh_in_hold", mem_valid_o, 1'b1);
        chk("rh_cnt4", st_cnt_o, 3'd4);
        step();
        rst_i       = 1'b0;
        mem_ready_i = 1'b1;
        req_valid_i = 3'b001;
        smp();
        chk("rh_mem_valid", mem_valid_o, 1'b0);
        chk("rh_cnt", st_cnt_o, 3'd0);
        chk("rh_mem_tid", mem_tid_o, 4'h0);
        chk("rh_idle_grant", req_ready_o, 3'b001);
        step();
        req_valid_i = 3'b000;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wt_mem_port_arbiter.md
Name: wt_mem_port_arbiter

Overview:
- Shares the single memory request port of the write-through cache subsystem among three requesters: I-cache refill (0), D-cache read miss (1) and write-buffer store (2).
- Enforces the outstanding-store limit and non-idempotent load ordering.
- Provides a drain handshake for fence and flush.
- Sits between the caches/write buffer and the NoC adapter.

Parameters:
- ADDR_W, 32, physical request address width.
- DATA_W, 64, store data width.
- TID_W, 2, requester-local transaction id width.
- MAX_OUT_STORES, 7, maximum un-acked stores in flight.
- NI_BASE, 32'h0000_0000, non-idempotent region base.
- NI_LEN, 32'h0001_0000, non-idempotent region length in bytes.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  3  per-requester request valid; bit index = requester id
- req_ready_o  out  3  per-requester accept, one-hot or zero
- req_addr_i  in  3*ADDR_W  per-requester address
- req_tid_i  in  3*TID_W  per-requester transaction id
- st_data_i  in  DATA_W  store data (requester 2 only)
- st_be_i  in  DATA_W/8  store byte enables
- mem_valid_o  out  1  memory request valid
- mem_ready_i  in  1  memory request accept
- mem_addr_o  out  ADDR_W  granted address
- mem_is_store_o  out  1  granted request is a store
- mem_data_o  out  DATA_W  store data
- mem_be_o  out  DATA_W/8  store byte enables
- mem_tid_o  out  TID_W+2  {requester id, local tid}
- rtrn_valid_i  in  1  memory response valid
- rtrn_tid_i  in  TID_W+2  response tag
- rtrn_valid_o  out  3  response routed one-hot by rtrn_tid_i[TID_W+1:TID_W]
- rtrn_tid_o  out  TID_W  local tid to requester
- drain_req_i  in  1  fence/flush drain request (level)
- drain_done_o  out  1  one-cycle pulse when drain completes
- st_cnt_o  out  3  current outstanding store count

Behaviour:
- FSM states:
  - IDLE: no request presented.
  - HOLD: granted request presented, waiting for mem_ready_i.
  - DRAIN: no new grants, waiting for store count = 0.
- Reset: state IDLE; rr pointer 0; st_cnt 0; mem_valid_o 0; req_ready_o 0; drain_done_o 0; rtrn_valid_o 0; mem_* data/addr/tid 0.
- Eligibility, evaluated combinationally in IDLE:
  - Requester 2 is eligible only if st_cnt < MAX_OUT_STORES.
  - Requester 1 is ineligible if its address lies in [NI_BASE, NI_BASE+NI_LEN) and st_cnt != 0.
  - Requester 0 is always eligible.
- Arbitration:
  - Round-robin starting at rr pointer among eligible valid requesters.
  - Winner gets req_ready_o pulse (1 cycle) and is registered into mem_* outputs.
  - FSM goes to HOLD with mem_valid_o=1 from the next cycle; request-to-mem latency is 1 cycle.
- HOLD:
  - mem_* outputs stable while mem_ready_i=0.
  - On mem_valid_o && mem_ready_i: rr pointer <= winner+1 (mod 3).
  - If the winner was a store, st_cnt increments.
  - Next state IDLE, or DRAIN if drain_req_i=1.
  - No back-to-back grant in the same cycle as handshake; max throughput 1 request per 2 cycles.
- Store ack:
  - rtrn_valid_i with tag id 2 decrements st_cnt.
  - Simultaneous increment and decrement leaves st_cnt unchanged.
  - Decrement at 0 is illegal: assertion, counter saturates at 0.
- Response routing:
  - rtrn_valid_o and rtrn_tid_o are combinational from rtrn_valid_i/rtrn_tid_i (0-cycle latency).
  - Tag id 3 is dropped and flagged by assertion.
- Drain:
  - drain_req_i seen in IDLE enters DRAIN. In HOLD, the current request completes first.
  - In DRAIN, req_ready_o=0.
  - When st_cnt=0, drain_done_o pulses 1 cycle and the FSM returns to IDLE, then waits for drain_req_i to fall before re-entering DRAIN.
  - If st_cnt is already 0 on entry, the pulse occurs the cycle after entry.
- Reset mid-HOLD: request is dropped, mem_valid_o=0 next cycle, st_cnt cleared; in-flight responses after reset are ignored for counting.

Optional Feature:
- Macro WT_MEM_ARB_PERF_EN adds output perf_stall_o (3x16): per-requester saturating counters of cycles with req_valid_i=1 and no req_ready_o. Counters are cleared by reset.
- Without the macro, the port and counters are absent and behaviour is otherwise identical.

Test Plan:
- All three valid continuously, mem_ready_i=1, st_cnt ack immediately -> grants in order 0,1,2,0,1,2; mem_tid_o upper bits match; one request per 2 cycles.
- Store flood, no acks -> exactly 7 stores accepted; st_cnt_o=7; requester 2 stalls; one ack -> 8th store granted 2 cycles later.
- 2 stores outstanding, D-cache read to NI_BASE+0x10 -> read blocked; I-cache read granted; after 2 acks the read is granted; read to 0x8000_0000 is not blocked.
- mem_ready_i held low 5 cycles in HOLD -> mem_addr_o/mem_tid_o stable, req_ready_o=0 throughout.
- 3 stores outstanding, drain_req_i=1 -> no grants; drain_done_o pulses 1 cycle after the 3rd ack.
- Reset asserted during HOLD with st_cnt=4 -> next cycle mem_valid_o=0, st_cnt_o=0, state IDLE.
